// File: rtl/boot_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : boot_seq_pkg
// Description : Shared types and constants for the PULPino boot sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package boot_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_HOLD  = 3'd1,
        SETTLE    = 3'd2,
        CFG       = 3'd3,
        LOAD      = 3'd4,
        FETCH_DLY = 3'd5,
        RUN       = 3'd6,
        DONE      = 3'd7
    } boot_state_t;

    typedef enum logic [1:0] {
        SRC_STANDALONE = 2'd0,
        SRC_PRELOAD    = 2'd1,
        SRC_SPI        = 2'd2
    } load_src_t;

    typedef enum logic [1:0] {
        ST_NONE    = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } boot_status_t;

    localparam logic [31:0] c_boot_reg_addr = 32'h1A10_7008;
    localparam int unsigned c_cnt_w         = 16;

endpackage
`default_nettype wire

// File: rtl/boot_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : boot_seq_ctrl_if
// Description : Config write request/grant port toward the boot-address register.
// Revision    : 1.0 - initial release
// ============================================================================
interface boot_seq_ctrl_if;
    logic        cfg_req;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_gnt;

    modport master (output cfg_req, output cfg_addr, output cfg_wdata, input cfg_gnt);
    modport slave  (input cfg_req, input cfg_addr, input cfg_wdata, output cfg_gnt);
endinterface
`default_nettype wire

// File: rtl/boot_seq_cnt.sv
`default_nettype none
// ============================================================================
// Module      : boot_seq_cnt
// Description : Loadable down-counter with zero flag, shared by the timed phases.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_seq_cnt
    import boot_seq_pkg::*;
#(
    parameter int unsigned WIDTH = c_cnt_w
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/boot_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : boot_seq_ctrl
// Description : Hardware PULPino bring-up: reset, boot-address write, load wait,
//               fetch enable and end-of-computation monitoring.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_seq_ctrl
    import boot_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES  = 16,
    parameter int unsigned SETTLE_CYCLES    = 12,
    parameter int unsigned FETCH_DLY_CYCLES = 5,
    parameter logic [31:0] BOOT_REG_ADDR    = c_boot_reg_addr,
    parameter int unsigned EOC_BIT          = 8,
    parameter int unsigned RES_BIT          = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [1:0]       load_src_i,
    input  logic [31:0]      boot_addr_i,
    input  logic [31:0]      timeout_i,
    input  logic             load_done_i,
    boot_seq_ctrl_if.master  cfg,
    output logic             core_rst_no,
    output logic             fetch_enable_o,
    input  logic [31:0]      gpio_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       status_o
);

    // Counter holds N-1 on entry so a phase lasts exactly N cycles.
    localparam logic [c_cnt_w-1:0] c_rst_hold_ld  = c_cnt_w'(RST_HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_settle_ld    = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_fetch_dly_ld = c_cnt_w'(FETCH_DLY_CYCLES - 1);

    boot_state_t         r_state;
    boot_state_t         w_next;
    boot_status_t        r_status;
    boot_status_t        w_next_status;
    logic [1:0]          r_src;
    logic [31:0]         r_boot_addr;
    logic [31:0]         r_timeout;
    logic [31:0]         r_run_cnt;
    logic                w_busy;
    logic                w_standalone;
    logic                w_tmo_hit;
    logic                w_cnt_load;
    logic                w_cnt_en;
    logic                w_cnt_zero;
    logic [c_cnt_w-1:0]  w_cnt_val;
    logic                w_unused_gpio;

    assign w_busy       = (r_state != IDLE) && (r_state != DONE);
    assign w_standalone = (r_src == SRC_STANDALONE);
    assign w_tmo_hit    = (r_timeout != 32'd0) && (r_run_cnt == r_timeout - 32'd1);
    assign w_unused_gpio = ^gpio_out_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_status    <= ST_NONE;
            r_src       <= '0;
            r_boot_addr <= '0;
            r_timeout   <= '0;
            r_run_cnt   <= '0;
        end else begin
            r_state  <= w_next;
            r_status <= w_next_status;
            if (!w_busy && start_i) begin
                r_src       <= load_src_i;
                r_boot_addr <= boot_addr_i;
                r_timeout   <= timeout_i;
            end
            r_run_cnt <= (r_state == RUN) ? r_run_cnt + 32'd1 : 32'd0;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_next_status = r_status;
        case (r_state)
            IDLE, DONE: begin
                if (start_i) begin
                    w_next        = RST_HOLD;
                    w_next_status = ST_NONE;
                end
            end
            RST_HOLD:  if (w_cnt_zero) w_next = SETTLE;
            SETTLE:    if (w_cnt_zero) w_next = w_standalone ? LOAD : CFG;
            CFG:       if (cfg.cfg_gnt) w_next = LOAD;
            LOAD:      if (w_standalone || load_done_i) w_next = FETCH_DLY;
            FETCH_DLY: if (w_cnt_zero) w_next = RUN;
            RUN: begin
                if (gpio_out_i[EOC_BIT]) begin
                    w_next        = DONE;
                    w_next_status = gpio_out_i[RES_BIT] ? ST_FAIL : ST_PASS;
                end else if (w_tmo_hit) begin
                    w_next        = DONE;
                    w_next_status = ST_TIMEOUT;
                end
            end
            default:   w_next = IDLE;
        endcase
        if (abort_i && w_busy) begin
            w_next        = IDLE;
            w_next_status = ST_NONE;
        end
    end

    always_comb begin
        w_cnt_val = '0;
        case (w_next)
            RST_HOLD:  w_cnt_val = c_rst_hold_ld;
            SETTLE:    w_cnt_val = c_settle_ld;
            FETCH_DLY: w_cnt_val = c_fetch_dly_ld;
            default:   w_cnt_val = '0;
        endcase
    end

    assign w_cnt_load = (w_next != r_state) &&
                        ((w_next == RST_HOLD) || (w_next == SETTLE) || (w_next == FETCH_DLY));
    assign w_cnt_en   = (r_state == RST_HOLD) || (r_state == SETTLE) || (r_state == FETCH_DLY);

    boot_seq_cnt #(
        .WIDTH (c_cnt_w)
    ) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_en       (w_cnt_en),
        .o_zero     (w_cnt_zero)
    );

    assign core_rst_no    = (r_state != IDLE) && (r_state != RST_HOLD);
    assign fetch_enable_o = (r_state == RUN);
    assign cfg.cfg_req    = (r_state == CFG);
    assign cfg.cfg_addr   = (r_state == CFG) ? BOOT_REG_ADDR : 32'd0;
    assign cfg.cfg_wdata  = (r_state == CFG) ? r_boot_addr : 32'd0;
    assign busy_o         = w_busy;
    assign done_o         = (r_state == DONE);
    assign status_o       = r_status;

endmodule
`default_nettype wire

// File: tb/tb_boot_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_boot_seq_ctrl
// Description : Directed self-checking bench for boot_seq_ctrl with a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_seq_ctrl;
    import boot_seq_pkg::*;

    localparam logic [31:0] c_reg_addr = 32'h1A10_7008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  load_src = 2'd0;
    logic [31:0] boot_addr = 32'd0;
    logic [31:0] timeout = 32'd0;
    logic        load_done = 1'b0;
    logic [31:0] gpio = 32'd0;
    logic        core_rst_no, fetch_enable_o, busy_o, done_o;
    logic [1:0]  status_o;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } cfg_exp_t;

    cfg_exp_t   q_cfg[$];
    logic [1:0] q_status[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_req_cycles = 0;
    logic       r_done_d = 1'b0;

    always #5 clk = ~clk;

    boot_seq_ctrl_if cfg_bus ();

    boot_seq_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .abort_i        (abort),
        .load_src_i     (load_src),
        .boot_addr_i    (boot_addr),
        .timeout_i      (timeout),
        .load_done_i    (load_done),
        .cfg            (cfg_bus.master),
        .core_rst_no    (core_rst_no),
        .fetch_enable_o (fetch_enable_o),
        .gpio_out_i     (gpio),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .status_o       (status_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return core_rst_no;
            1:       return cfg_bus.cfg_req;
            2:       return fetch_enable_o;
            default: return done_o;
        endcase
    endfunction

    // Bounded wait; an expired bound shows up as a latency mismatch.
    task automatic wait_for(input int sel, input int limit, output int n);
        n = 0;
        while ((probe(sel) !== 1'b1) && (n < limit)) begin
            step();
            n++;
        end
    endtask

    task automatic do_start(input logic [1:0] src, input logic [31:0] ba, input logic [31:0] tmo);
        load_src  = src;
        boot_addr = ba;
        timeout   = tmo;
        start     = 1'b1;
        step();
        start     = 1'b0;
        load_src  = ~src;
        boot_addr = ~ba;
        timeout   = 32'd3;
    endtask

    task automatic check_idle(input string tag, input logic [1:0] st);
        chk({tag, "_core_rst_no"}, core_rst_no, 0);
        chk({tag, "_fetch"}, fetch_enable_o, 0);
        chk({tag, "_req"}, cfg_bus.cfg_req, 0);
        chk({tag, "_addr"}, cfg_bus.cfg_addr, 0);
        chk({tag, "_wdata"}, cfg_bus.cfg_wdata, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_status"}, status_o, st);
    endtask

    // Scoreboard side: config writes and completion status as the DUT emits them.
    always @(negedge clk) begin : mon
        cfg_exp_t e;
        if (cfg_bus.cfg_req) n_req_cycles++;
        if (cfg_bus.cfg_req && cfg_bus.cfg_gnt) begin
            chk("cfg_write_expected", q_cfg.size() != 0, 1);
            if (q_cfg.size() != 0) begin
                e = q_cfg.pop_front();
                chk("cfg_addr", cfg_bus.cfg_addr, e.addr);
                chk("cfg_wdata", cfg_bus.cfg_wdata, e.data);
            end
        end
        if (done_o && !r_done_d) begin
            chk("done_expected", q_status.size() != 0, 1);
            if (q_status.size() != 0) chk("done_status", status_o, q_status.pop_front());
        end
        r_done_d = done_o;
    end

    initial begin
        int n;
        int req0;
        logic stable;
        cfg_bus.cfg_gnt = 1'b0;

        step();
        step();
        rst = 1'b0;
        check_idle("reset", ST_NONE);

        // SPI boot, pass path
        do_start(2'd2, 32'd0, 32'd0);
        chk("t1_busy", busy_o, 1);
        wait_for(0, 100, n);
        chk("t1_rst_release_lat", n, 16);
        wait_for(1, 100, n);
        chk("t1_cfg_req_lat", n, 12);
        q_cfg.push_back('{addr: c_reg_addr, data: 32'd0});
        repeat (3) step();
        chk("t1_req_held", cfg_bus.cfg_req, 1);
        cfg_bus.cfg_gnt = 1'b1;
        step();
        cfg_bus.cfg_gnt = 1'b0;
        chk("t1_req_dropped", cfg_bus.cfg_req, 0);
        repeat (100) step();
        chk("t1_load_wait_fetch", fetch_enable_o, 0);
        chk("t1_load_wait_busy", busy_o, 1);
        load_done = 1'b1;
        // one LOAD cycle samples load_done, then five FETCH_DLY cycles
        wait_for(2, 20, n);
        chk("t1_fetch_lat", n, 6);
        repeat (50) step();
        chk("t1_run_not_done", done_o, 0);
        gpio = 32'h0000_0100;
        q_status.push_back(ST_PASS);
        step();
        gpio = 32'd0;
        load_done = 1'b0;
        chk("t1_done", done_o, 1);
        chk("t1_status", status_o, ST_PASS);
        chk("t1_fetch_off", fetch_enable_o, 0);
        chk("t1_core_out_of_rst", core_rst_no, 1);
        chk("t1_busy_off", busy_o, 0);
        chk("t1_single_write", q_cfg.size(), 0);

        // STANDALONE boot from DONE, fail result
        req0 = n_req_cycles;
        do_start(2'd0, 32'h5555_5555, 32'd0);
        chk("t2_done_cleared", done_o, 0);
        chk("t2_status_cleared", status_o, ST_NONE);
        wait_for(2, 100, n);
        chk("t2_fetch_lat", n, 34);
        chk("t2_no_cfg_req", n_req_cycles - req0, 0);
        gpio = 32'h0000_0300;
        q_status.push_back(ST_FAIL);
        step();
        gpio = 32'd0;
        chk("t2_status_fail", status_o, ST_FAIL);

        // PRELOAD with early grant, load already done, timeout 20
        cfg_bus.cfg_gnt = 1'b1;
        load_done = 1'b1;
        do_start(2'd1, 32'h0000_8000, 32'd20);
        q_cfg.push_back('{addr: c_reg_addr, data: 32'h0000_8000});
        repeat (4) step();
        chk("t3_gnt_ignored", core_rst_no, 0);
        wait_for(2, 100, n);
        chk("t3_fetch_lat", n, 31);
        cfg_bus.cfg_gnt = 1'b0;
        load_done = 1'b0;
        q_status.push_back(ST_TIMEOUT);
        wait_for(3, 50, n);
        chk("t3_timeout_lat", n, 20);
        chk("t3_status_tmo", status_o, ST_TIMEOUT);
        chk("t3_fetch_off", fetch_enable_o, 0);

        // EOC on the same cycle as the timeout
        do_start(2'd0, 32'd0, 32'd20);
        wait_for(2, 100, n);
        chk("t4_fetch_lat", n, 34);
        repeat (19) step();
        chk("t4_not_done_yet", done_o, 0);
        gpio = 32'h0000_0100;
        q_status.push_back(ST_PASS);
        step();
        gpio = 32'd0;
        chk("t4_done", done_o, 1);
        chk("t4_eoc_wins", status_o, ST_PASS);

        // Grant withheld for 40 cycles, start ignored, then abort in CFG
        do_start(2'd2, 32'hDEAD_BEEF, 32'd0);
        wait_for(1, 100, n);
        chk("t5_cfg_req_lat", n, 28);
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) begin
                start = 1'b1;
                boot_addr = 32'h0BAD_0BAD;
            end
            step();
            start = 1'b0;
            if (!(cfg_bus.cfg_req === 1'b1 && cfg_bus.cfg_addr === c_reg_addr &&
                  cfg_bus.cfg_wdata === 32'hDEAD_BEEF && busy_o === 1'b1 &&
                  core_rst_no === 1'b1)) stable = 1'b0;
        end
        chk("t5_hold_stable", stable, 1);
        chk("t5_wdata", cfg_bus.cfg_wdata, 32'hDEAD_BEEF);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("t5_abort", ST_NONE);
        step();
        chk("t5_stays_idle", busy_o, 0);

        // Abort in RUN, together with a start pulse
        do_start(2'd0, 32'd0, 32'd0);
        wait_for(2, 100, n);
        chk("t6_fetch_lat", n, 34);
        repeat (5) step();
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check_idle("t6_abort", ST_NONE);

        // Reset in RUN, then a clean sequence with immediate grant/load/EOC
        do_start(2'd0, 32'd0, 32'd0);
        wait_for(2, 100, n);
        chk("t7_fetch_lat", n, 34);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("t7_reset", ST_NONE);
        cfg_bus.cfg_gnt = 1'b1;
        load_done = 1'b1;
        gpio = 32'h0000_0100;
        q_cfg.push_back('{addr: c_reg_addr, data: 32'h1234_5678});
        q_status.push_back(ST_PASS);
        do_start(2'd3, 32'h1234_5678, 32'd0);
        wait_for(0, 100, n);
        chk("t7_rst_release_lat", n, 16);
        wait_for(2, 100, n);
        chk("t7_fetch_lat_fast", n, 19);
        step();
        chk("t7_done_one_run", done_o, 1);
        chk("t7_status", status_o, ST_PASS);
        cfg_bus.cfg_gnt = 1'b0;
        load_done = 1'b0;
        gpio = 32'd0;

        step();
        chk("end_cfg_queue", q_cfg.size(), 0);
        chk("end_status_queue", q_status.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
